seq_muldiv: RTL and testbench
=============================

Name: seq_muldiv

Overview:
- Multi-cycle multiply/divide unit that answers execute-stage requests from the pipeline, which acts as the initiator.
- Replaces the single-cycle multiply path with an iterative shift-add multiplier and a restoring divider.
- Reports completion through a busy/valid handshake so the hazard logic can stall the pipeline.
- Operation codes use the same 4-bit ALU control space as the rest of the execute stage.

Parameters:
- WIDTH, 32, operand and result width in bits (even, at least 4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  request strobe; sampled only in IDLE.
- op_i  in  4  operation code: MUL=4'b1010, DIV=4'b1011, REM=4'b1100.
- data1_i  in  WIDTH  operand A (dividend for DIV/REM).
- data2_i  in  WIDTH  operand B (divisor for DIV/REM).
- busy_o  out  1  high while an operation is in flight; drives the pipeline stall.
- valid_o  out  1  one-cycle pulse marking data_o as the new result.
- data_o  out  WIDTH  result; holds its value until the next completion.

Behaviour:
- Reset: when rst_i is high at a clock edge, the state goes to IDLE and busy_o, valid_o, data_o and the counter all clear to 0. This applies in any state and aborts an in-flight operation with no valid_o pulse.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 latches op_i, data1_i and data2_i and moves to RUN; the counter loads WIDTH.
  - An op_i outside {MUL, DIV, REM} still runs the full sequence and produces result 0.
- RUN:
  - One iteration per cycle; the counter decrements each cycle.
  - The state moves to DONE on the cycle the counter reaches 1.
  - start_i is ignored, and input changes have no effect.
- DONE:
  - valid_o=1 for exactly one cycle, with data_o updated in the same cycle.
  - Returns to IDLE on the next edge.
  - start_i is not sampled in DONE; the earliest back-to-back start is the first IDLE cycle.
- busy_o is 1 in RUN and DONE, and 0 in IDLE.
- Latency is fixed and independent of operand values. If start_i is sampled at edge t:
  - busy_o rises after edge t.
  - valid_o is high in the cycle following edge t+WIDTH (WIDTH+1 cycles from start to result).
- MUL:
  - Unsigned shift-add over a 2*WIDTH product register.
  - data_o takes the low WIDTH bits, which are identical for signed and unsigned operands.
- DIV and REM:
  - Signed, with the quotient truncated toward zero.
  - The remainder takes the sign of the dividend.
  - The core is an unsigned restoring divider on magnitudes, with sign correction applied in DONE.
- Divide by zero (B=0): DIV returns all ones; REM returns A.
- Overflow (A = most negative value, B = -1): DIV returns A; REM returns 0.
- Both special cases take the same fixed latency.
- All arithmetic wraps modulo 2^WIDTH; there is no overflow or flag output.

Decomposition:
- Shared package (alu_pkg) holds:
  - the 4-bit ALU control constants for ADD, SUB, AND, OR, MUL, DIV and REM, shared with the ALU control block;
  - the state encoding for IDLE, RUN and DONE.
- One natural sub-module, seq_divider_core: the unsigned restoring iteration, taking magnitudes and returning quotient and remainder.
- The multiplier datapath, sign handling, special cases and FSM stay in seq_muldiv.

Test Plan:
- MUL 7 x 6, start at edge t -> busy_o high after edge t; valid_o high exactly one cycle after edge t+32; data_o=42; busy_o low one cycle later.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> data_o=0x00000001. MUL 0x80000000 x 2 -> data_o=0x00000000.
- DIV -7 / 2 -> data_o=0xFFFFFFFD (-3). REM -7 / 2 -> data_o=0xFFFFFFFF (-1). REM 7 / -2 -> data_o=1.
- DIV 5 / 0 -> data_o=0xFFFFFFFF; REM 5 / 0 -> data_o=5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. All cases at the fixed 33-cycle latency.
- Start MUL 3 x 3, then pulse start_i with DIV 9/3 in RUN cycle 5 -> second request ignored; data_o=9; exactly one valid_o pulse.
- Start MUL, assert rst_i in RUN cycle 10 -> after that edge busy_o=0, valid_o=0, data_o=0, no later valid_o; a new MUL 2 x 5 afterwards -> data_o=10 at normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Execute-stage ALU control codes and the multiply/divide unit state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b1010;
    localparam logic [3:0] ALU_DIV = 4'b1011;
    localparam logic [3:0] ALU_REM = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/seq_muldiv_if.sv
// Request/response handshake between the pipeline (master) and seq_muldiv (slave).
interface seq_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;

    modport master (
        output start_i, op_i, data1_i, data2_i,
        input  busy_o, valid_o, data_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i,
        output busy_o, valid_o, data_o
    );
endinterface

// File: rtl/seq_divider_core.sv
// Unsigned restoring divider: one quotient bit per step, operands loaded as magnitudes.
module seq_divider_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // diff[WIDTH] set means the trial subtraction went negative: restore.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, div_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            div_q <= divisor_i;
        end else if (step_i) begin
            quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_q <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
endmodule

// File: rtl/seq_muldiv.sv
// Iterative multiply/divide unit: shift-add MUL, signed DIV/REM on a restoring core,
// fixed WIDTH+1 cycle latency with busy/valid handshake.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    seq_muldiv_if.slave  bus
);
    md_state_e          state_q, state_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] prod_q, prod_step;
    logic [WIDTH:0]     prod_sum;
    logic [WIDTH-1:0]   data_q, result;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic               a_neg, b_neg, div_zero, div_ovf, start_ok;

    assign start_ok = (state_q == ST_IDLE) && bus.start_i;
    assign mag_a    = bus.data1_i[WIDTH-1] ? -bus.data1_i : bus.data1_i;
    assign mag_b    = bus.data2_i[WIDTH-1] ? -bus.data2_i : bus.data2_i;

    seq_divider_core #(.WIDTH(WIDTH)) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (start_ok),
        .step_i      (state_q == ST_RUN),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (bus.start_i) state_n = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_W'(1)) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Shift-add step: add A into the upper half when the multiplier LSB is set, then shift right.
    always_comb begin
        prod_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_step = {prod_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        a_neg    = a_q[WIDTH-1];
        b_neg    = b_q[WIDTH-1];
        div_zero = (b_q == '0);
        div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        result   = '0;
        case (op_q)
            ALU_MUL: result = prod_q[WIDTH-1:0];
            ALU_DIV: begin
                if (div_zero)     result = '1;
                else if (div_ovf) result = a_q;
                else              result = (a_neg ^ b_neg) ? -quo : quo;
            end
            ALU_REM: begin
                if (div_zero)     result = a_q;
                else if (div_ovf) result = '0;
                else              result = a_neg ? -rem : rem;
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start_i) begin
                    cnt_q  <= CNT_W'(WIDTH);
                    op_q   <= bus.op_i;
                    a_q    <= bus.data1_i;
                    b_q    <= bus.data2_i;
                    prod_q <= {{WIDTH{1'b0}}, bus.data2_i};
                end
                ST_RUN: begin
                    cnt_q  <= cnt_q - CNT_W'(1);
                    prod_q <= prod_step;
                end
                ST_DONE: data_q <= result;
                default: ;
            endcase
        end
    end

    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.valid_o = (state_q == ST_DONE);
    assign bus.data_o  = (state_q == ST_DONE) ? result : data_q;
endmodule

// File: tb/tb_seq_muldiv.sv
// Directed scoreboard bench for seq_muldiv: stimulus queues expectations, a monitor checks each valid_o.
module tb_seq_muldiv;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    seq_muldiv_if #(.WIDTH(W)) bus ();

    seq_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid_o must match the oldest queued expectation in data and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got valid_o=1 at cycle %0d expected no result", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_data"}, bus.data_o, e.data);
                    check({e.name, "_latency"}, W'(cyc), W'(e.cyc));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string name, input bit expect_result);
        exp_t e;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
        if (expect_result) begin
            e.data = exp;
            e.cyc  = cyc + 1 + W;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.op_i    = 4'hF;
        bus.data1_i = '1;
        bus.data2_i = '1;
        check({name, "_busy_rise"}, W'(bus.busy_o), W'(1));
    endtask

    task automatic wait_done(input logic [W-1:0] exp, input string name);
        int n = 0;
        while (bus.valid_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.valid_o !== 1'b1) begin
            check({name, "_timeout"}, W'(bus.valid_o), W'(1));
        end else begin
            check({name, "_busy_done"}, W'(bus.busy_o), W'(1));
            @(negedge clk);
            check({name, "_busy_fall"}, W'(bus.busy_o), W'(0));
            check({name, "_valid_fall"}, W'(bus.valid_o), W'(0));
            check({name, "_hold"}, bus.data_o, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input string name);
        issue(op, a, b, exp, name, 1'b1);
        wait_done(exp, name);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", W'(bus.busy_o), W'(0));
        check("reset_valid", W'(bus.valid_o), W'(0));
        check("reset_data", bus.data_o, '0);

        run_op(ALU_MUL, 32'd7, 32'd6, 32'd42, "mul_7x6");
        run_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff");
        run_op(ALU_MUL, 32'h8000_0000, 32'd2, 32'h0000_0000, "mul_wrap");
        run_op(ALU_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        run_op(ALU_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        run_op(ALU_REM, 32'd7, -32'sd2, 32'd1, "rem_7_m2");
        run_op(ALU_DIV, 32'd100, 32'd7, 32'd14, "div_100_7");
        run_op(ALU_REM, 32'd100, 32'd7, 32'd2, "rem_100_7");
        run_op(ALU_DIV, -32'sd100, -32'sd7, 32'd14, "div_m100_m7");
        run_op(ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0");
        run_op(ALU_REM, 32'd5, 32'd0, 32'd5, "rem_by0");
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
        run_op(ALU_ADD, 32'd3, 32'd4, 32'd0, "unsupported_op");

        // Second start while in RUN cycle 5 must be ignored.
        issue(ALU_MUL, 32'd3, 32'd3, 32'd9, "mul_ignore", 1'b1);
        repeat (4) @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = ALU_DIV;
        bus.data1_i = 32'd9;
        bus.data2_i = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(32'd9, "mul_ignore");
        repeat (40) @(negedge clk);

        // Reset in RUN cycle 10 aborts with no result.
        issue(ALU_MUL, 32'd4, 32'd4, 32'd16, "mul_abort", 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", W'(bus.busy_o), W'(0));
        check("abort_valid", W'(bus.valid_o), W'(0));
        check("abort_data", bus.data_o, '0);
        repeat (40) @(negedge clk);

        run_op(ALU_MUL, 32'd2, 32'd5, 32'd10, "mul_after_rst");
        repeat (5) @(negedge clk);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
